fifo_rd_block: RTL



---
 rtl/fifo_rd_block_pkg.sv | 17 +
 rtl/fifo_rd_block_grey_bin.sv | 22 ++
 rtl/fifo_rd_block.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_rd_block_pkg.sv
// Shared definitions for the async FIFO read/write control blocks.
// Latency: n/a (types, defaults and pure functions only).
// Backpressure: n/a.
package fifo_rd_block_pkg;

    localparam int ADDR_WIDTH_DEF = 3;
    localparam int BUS_WIDTH_DEF  = 8;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;
    localparam int AE_TH_DEF      = 1;

    // Binary to reflected Gray code. Callers truncate the result to their
    // pointer width; the upper bits are zero for any narrower input.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_rd_block_grey_bin.sv
// Gray-to-binary decoder, inverse of bin2gray.
// Latency: purely combinational (XOR prefix from the MSB down).
// Backpressure: n/a.
// Ports: gray_i  Gray-coded input, WIDTH bits
//        bin_o   binary equivalent, WIDTH bits
module grey_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // bin[i] is the XOR of all Gray bits at position i and above; computed
    // from the shifted input so no bit depends on another output bit.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_block.sv
// Read-side control of the async FIFO: read pointer, empty, occupancy, read data register.
// Latency: 1 cycle from an accepted request (read_enable) to r_data/r_valid.
// Backpressure: requests while empty are dropped and flagged in sticky r_underflow.
// Ports: r_clk/r_rst clock and sync active-high reset; r_en read request;
//        wptr_sync synchronized Gray write pointer; mem_rdata/r_addr memory read port;
//        rptr_out Gray read pointer to write domain; read_enable qualified pop;
//        r_empty/r_almost_empty/r_count occupancy status; r_data/r_valid popped word;
//        r_underflow sticky read-while-empty flag.
module fifo_rd_block
    import fifo_rd_block_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int bus_width  = BUS_WIDTH_DEF,
    parameter int AE_TH      = AE_TH_DEF
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   wptr_sync,
    input  logic [bus_width-1:0]  mem_rdata,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   rptr_out,
    output logic                  read_enable,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   r_count,
    output logic [bus_width-1:0]  r_data,
    output logic                  r_valid,
    output logic                  r_underflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Thresholds above DEPTH behave like DEPTH (almost-empty always set).
    localparam int AE_CLAMP = (AE_TH > DEPTH) ? DEPTH : AE_TH;
    localparam logic [ADDR_WIDTH:0] AE_TH_W = PW'(AE_CLAMP);

    logic [ADDR_WIDTH:0]  rbin_q, rbin_d;
    logic [ADDR_WIDTH:0]  rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]  wbin;
    logic [bus_width-1:0] r_data_q, r_data_d;
    logic                 r_valid_q, r_valid_d;
    logic                 r_underflow_q, r_underflow_d;

    grey_bin #(.WIDTH(PW)) u_wptr_dec (
        .gray_i (wptr_sync),
        .bin_o  (wbin)
    );

    // Both compared pointers are registered Gray values, so the empty flag
    // is glitch-free and tracks a same-cycle wptr_sync advance directly.
    assign r_empty     = (rptr_q == wptr_sync);
    assign read_enable = r_en && !r_empty;

    // Stale wptr_sync can only lag the real write pointer, so this never over-reports.
    assign r_count        = wbin - rbin_q;
    assign r_almost_empty = (r_count <= AE_TH_W);

    always_comb begin
        rbin_d        = rbin_q + PW'(read_enable);
        rptr_d        = PW'(bin2gray(32'(rbin_d)));
        r_data_d      = read_enable ? mem_rdata : r_data_q;
        r_valid_d     = read_enable;
        r_underflow_d = r_underflow_q | (r_en & r_empty);
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rbin_q        <= '0;
            rptr_q        <= '0;
            r_data_q      <= '0;
            r_valid_q     <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            rbin_q        <= rbin_d;
            rptr_q        <= rptr_d;
            r_data_q      <= r_data_d;
            r_valid_q     <= r_valid_d;
            r_underflow_q <= r_underflow_d;
        end
    end

    assign r_addr      = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_out    = rptr_q;
    assign r_data      = r_data_q;
    assign r_valid     = r_valid_q;
    assign r_underflow = r_underflow_q;

endmodule
